// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the memory-side bus of dmem_arbiter.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic [1:0]    gnt;
    logic          mem_e;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, gnt, mem_e, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, gnt, mem_e, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-ported data memory between two requesters.
// Each access takes IDLE -> ACCESS -> RESP, i.e. one access every three cycles.
module dmem_arbiter #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    logic          last_gnt;
    logic          owner;
    logic [1:0]    gnt_q;
    logic          ack0_q;
    logic          ack1_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic          mem_e_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          win_c;

    // On a tie the port that did not complete last wins.
    always_comb begin
        win_c = bus.req1;
        if (bus.req0 && bus.req1) begin
            win_c = ~last_gnt;
        end
    end

    // The mem_* registers double as the latched command of the current access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            owner       <= 1'b0;
            gnt_q       <= 2'b00;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_e_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner       <= win_c;
                        gnt_q       <= win_c ? 2'b10 : 2'b01;
                        mem_e_q     <= 1'b1;
                        mem_we_q    <= win_c ? bus.we1    : bus.we0;
                        mem_addr_q  <= win_c ? bus.addr1  : bus.addr0;
                        mem_wdata_q <= win_c ? bus.wdata1 : bus.wdata0;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!mem_we_q) begin
                        if (owner) begin
                            rdata1_q <= bus.mem_rdata;
                        end else begin
                            rdata0_q <= bus.mem_rdata;
                        end
                    end
                    ack0_q      <= ~owner;
                    ack1_q      <= owner;
                    last_gnt    <= owner;
                    mem_e_q     <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    state       <= RESP;
                end
                RESP: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    gnt_q  <= 2'b00;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.mem_e     = mem_e_q;
    // A reset landing in the access cycle must not commit the write.
    assign bus.mem_we    = mem_we_q & ~rst;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
